// File: rtl/level_sequencer_pkg.sv
// Shared types and constants for the Frogger level sequencer and its downstream comparator.
package level_sequencer_pkg;
    typedef logic [1:0] level_t;
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t PLAY = 2'd1;
    localparam state_t WIN  = 2'd2;

    // Final level; the comparator flags this value.
    localparam level_t LEVEL_MAX = 2'd3;
endpackage

// File: rtl/level_sequencer_if.sv
// Game-control inputs and progress outputs of the level sequencer.
interface level_sequencer_if;
    logic       start_InLow;
    logic       frog_arrive_InHigh;
    logic       frog_dead_InHigh;
    logic [1:0] level_OutBUS;
    logic [2:0] crossings_OutBUS;
    logic       speed_tick_OutHigh;
    logic       level_up_OutHigh;
    logic       playing_OutHigh;
    logic       win_OutHigh;

    modport master (
        output start_InLow, frog_arrive_InHigh, frog_dead_InHigh,
        input  level_OutBUS, crossings_OutBUS, speed_tick_OutHigh,
               level_up_OutHigh, playing_OutHigh, win_OutHigh
    );

    modport slave (
        input  start_InLow, frog_arrive_InHigh, frog_dead_InHigh,
        output level_OutBUS, crossings_OutBUS, speed_tick_OutHigh,
               level_up_OutHigh, playing_OutHigh, win_OutHigh
    );
endinterface

// File: rtl/level_speed_ticker.sv
// Level-dependent traffic pacing tick: one pulse every BASE_PERIOD - level*PERIOD_STEP clocks.
module level_speed_ticker
    import level_sequencer_pkg::*;
#(
    parameter int unsigned                TICK_DATAWIDTH = 23,
    parameter logic [TICK_DATAWIDTH-1:0]  BASE_PERIOD    = TICK_DATAWIDTH'(4_000_000),
    parameter logic [TICK_DATAWIDTH-1:0]  PERIOD_STEP    = TICK_DATAWIDTH'(1_000_000)
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    input  logic   clr_i,
    input  level_t level_i,
    output logic   tick_o
);
    logic [TICK_DATAWIDTH-1:0] period;
    logic [TICK_DATAWIDTH-1:0] cnt_q, cnt_d;
    logic                      last;
    logic                      tick_q, tick_d;

    assign period = BASE_PERIOD - TICK_DATAWIDTH'(level_i) * PERIOD_STEP;
    assign last   = (cnt_q == period - TICK_DATAWIDTH'(1));

    // The tick is judged on the old count, so a clear on the same edge never swallows it.
    always_comb begin
        cnt_d  = cnt_q + TICK_DATAWIDTH'(1);
        if (!en_i || clr_i || last) cnt_d = '0;
        tick_d = en_i && last;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
endmodule

// File: rtl/level_sequencer.sv
// Frogger game-progress sequencer: counts crossings, advances the level, paces traffic.
module level_sequencer
    import level_sequencer_pkg::*;
#(
    parameter int unsigned                CROSSINGS_PER_LEVEL = 4,
    parameter int unsigned                TICK_DATAWIDTH      = 23,
    parameter logic [TICK_DATAWIDTH-1:0]  BASE_PERIOD         = TICK_DATAWIDTH'(4_000_000),
    parameter logic [TICK_DATAWIDTH-1:0]  PERIOD_STEP         = TICK_DATAWIDTH'(1_000_000)
) (
    input  logic              CLOCK_50,
    input  logic              RESET_InHigh,
    level_sequencer_if.slave  bus
);
    state_t     state_q, state_d;
    level_t     level_q, level_d;
    logic [2:0] cross_q, cross_d;
    logic       lvlup_q, lvlup_d;
    logic       playing_q, playing_d;
    logic       win_q, win_d;
    logic       start_prev_q, arrive_prev_q, dead_prev_q;

    logic       start_fall, arrive_rise, dead_rise;
    logic       arrive_ok, full;
    logic [2:0] cross_inc;

    assign start_fall  = start_prev_q & ~bus.start_InLow;
    assign arrive_rise = bus.frog_arrive_InHigh & ~arrive_prev_q;
    assign dead_rise   = bus.frog_dead_InHigh & ~dead_prev_q;

    // A death on the same cycle discards the arrival.
    assign arrive_ok = (state_q == PLAY) && arrive_rise && !dead_rise;
    assign cross_inc = cross_q + 3'd1;
    assign full      = arrive_ok && (cross_inc == 3'(CROSSINGS_PER_LEVEL));

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_fall) state_d = PLAY;
            PLAY:    if (full && level_q == LEVEL_MAX) state_d = WIN;
            WIN:     if (start_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d   = level_q;
        cross_d   = cross_q;
        lvlup_d   = 1'b0;
        if (state_q == IDLE && start_fall) begin
            level_d = '0;
            cross_d = '0;
        end else if (state_q == PLAY) begin
            if (dead_rise) begin
                cross_d = '0;
            end else if (full && level_q != LEVEL_MAX) begin
                level_d = level_q + 2'd1;
                cross_d = '0;
                lvlup_d = 1'b1;
            end else if (arrive_ok) begin
                cross_d = cross_inc;
            end
        end
        playing_d = (state_d == PLAY);
        win_d     = (state_d == WIN);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            level_q       <= '0;
            cross_q       <= '0;
            lvlup_q       <= 1'b0;
            playing_q     <= 1'b0;
            win_q         <= 1'b0;
            start_prev_q  <= 1'b1;
            arrive_prev_q <= 1'b0;
            dead_prev_q   <= 1'b0;
        end else begin
            level_q       <= level_d;
            cross_q       <= cross_d;
            lvlup_q       <= lvlup_d;
            playing_q     <= playing_d;
            win_q         <= win_d;
            start_prev_q  <= bus.start_InLow;
            arrive_prev_q <= bus.frog_arrive_InHigh;
            dead_prev_q   <= bus.frog_dead_InHigh;
        end
    end

    level_speed_ticker #(
        .TICK_DATAWIDTH (TICK_DATAWIDTH),
        .BASE_PERIOD    (BASE_PERIOD),
        .PERIOD_STEP    (PERIOD_STEP)
    ) u_ticker (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET_InHigh),
        .en_i    (state_d == PLAY),
        .clr_i   (lvlup_d || state_q != PLAY),
        .level_i (level_q),
        .tick_o  (bus.speed_tick_OutHigh)
    );

    assign bus.level_OutBUS     = level_q;
    assign bus.crossings_OutBUS = cross_q;
    assign bus.level_up_OutHigh = lvlup_q;
    assign bus.playing_OutHigh  = playing_q;
    assign bus.win_OutHigh      = win_q;
endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-progress sequencer for the Frogger datapath. Counts successful frog crossings, advances the 2-bit level, and produces the level-dependent speed tick that paces traffic movement. Sits directly upstream of the level comparator: `level_OutBUS` drives the comparator's 2-bit level input, and the comparator flags the final level (2'b11).

## Interface
Parameters:
- `CROSSINGS_PER_LEVEL`, default 4: crossings required to leave a level; legal range 1..7.
- `TICK_DATAWIDTH`, default 23: width of the speed-tick counter.
- `BASE_PERIOD`, default 23'd4_000_000: tick period in clocks at level 0.
- `PERIOD_STEP`, default 23'd1_000_000: period reduction per level. `BASE_PERIOD - 3*PERIOD_STEP` must be ≥ 2.

Ports:
- `CLOCK_50`, in, 1: the block's only clock.
- `RESET_InHigh`, in, 1: reset, asynchronous, active-high.
- `start_InLow`, in, 1: start request, active-low level, edge-detected internally.
- `frog_arrive_InHigh`, in, 1: frog reached the far bank, level signal, rising-edge detected.
- `frog_dead_InHigh`, in, 1: frog collision, level signal, rising-edge detected.
- `level_OutBUS`, out, 2: current level 0..3; feeds the comparator.
- `crossings_OutBUS`, out, 3: crossings completed in the current level.
- `speed_tick_OutHigh`, out, 1: one-cycle pulse, once per level period, in PLAY only.
- `level_up_OutHigh`, out, 1: one-cycle pulse on each level advance.
- `playing_OutHigh`, out, 1: high in PLAY.
- `win_OutHigh`, out, 1: high in WIN.

## Operation
- States: IDLE, PLAY, WIN.
- Transitions:
  - IDLE→PLAY on a falling edge of `start_InLow`.
  - PLAY→WIN when a crossing at level 3 brings the count to `CROSSINGS_PER_LEVEL`.
  - WIN→IDLE on a falling edge of `start_InLow`.
- Edge detection: each input has its own previous-value register, reset to its inactive value (start 1, arrive 0, dead 0). An edge is the current sample against that register.
- Entering PLAY from IDLE: level=0, crossings=0, tick counter=0.
- Arrive edge in PLAY:
  - crossings+1.
  - If the new count equals `CROSSINGS_PER_LEVEL` and level<3: level+1, crossings=0, tick counter=0, `level_up_OutHigh` pulses.
  - If the new count equals `CROSSINGS_PER_LEVEL` and level==3: go to WIN. Level stays 3 and crossings holds the final count.
- Dead edge in PLAY: crossings=0, level unchanged.
- Arrive and dead edges on the same cycle: dead wins and the arrive is discarded.
- Arrive and dead edges outside PLAY are ignored.
- Speed tick, PLAY only:
  - Period P = `BASE_PERIOD - level*PERIOD_STEP`, computed at `TICK_DATAWIDTH` bits.
  - The counter counts 0..P-1. `speed_tick_OutHigh` is high on the cycle the counter equals P-1, then the counter wraps to 0.
  - Counter is held at 0 in IDLE and WIN.
  - Any crossing or death does not disturb the counter; only a level change clears it.
- Level saturates at 3 and never wraps to 0 except via the IDLE→PLAY restart.

## Timing
- All outputs are registered.
- Reset values: `level_OutBUS`=0, `crossings_OutBUS`=0, `speed_tick_OutHigh`=0, `level_up_OutHigh`=0, `playing_OutHigh`=0, `win_OutHigh`=0. State resets to IDLE.
- Latency: an input that is sampled asserted at clock edge N (after being sampled deasserted at edge N-1) has its updated outputs visible after edge N.
- `level_up_OutHigh` is high for exactly the cycle following that edge, coincident with the new `level_OutBUS`.
- First tick after entering PLAY or after a level change: P cycles later.
- Level change coincident with a tick cycle: the counter clears and the tick still fires for that cycle.
- Reset asserted mid-game: all state returns to reset values immediately, without waiting for a clock. After deassertion, the first falling `start_InLow` edge is needed to play again.
- An input held asserted counts once.

## Structure
- Shared package holds:
  - State encoding localparams: IDLE=2'd0, PLAY=2'd1, WIN=2'd2.
  - LEVEL_MAX=2'd3, which is also used by the comparator.
- One natural sub-module: `level_speed_ticker`. It takes level, an enable and a clear, and outputs the tick, holding the period computation and counter.
- FSM, edge detectors and crossing/level registers live in the top.

## Test plan
Bench parameters for all scenarios: `CROSSINGS_PER_LEVEL`=2, `BASE_PERIOD`=10, `PERIOD_STEP`=2.

- **Reset and start:** reset pulse, then `start_InLow` 1→0 → all outputs 0 during reset; `playing_OutHigh`=1 one cycle after the start edge, level=0.
- **Level advance:** two arrive pulses in PLAY → crossings 1 then 0; level 0→1; one `level_up_OutHigh` pulse. Repeat to level 3 and the comparator input reads 2'b11.
- **Death and collision priority:**
  - At level 1, crossings=1, a dead pulse → crossings=0, level stays 1.
  - Arrive and dead rising on the same cycle → crossings=0, no level_up.
- **Tick period:** hold PLAY at each level → tick spacing 10, 8, 6, 4 cycles. No ticks in IDLE or WIN.
- **Win and restart:** second crossing at level 3 → `win_OutHigh`=1, `playing_OutHigh`=0, level stays 3. Further arrives ignored. A start edge → IDLE; the next start edge → PLAY at level 0.
- **Async reset and held input:**
  - Assert reset mid-period at level 2 → outputs clear without a clock edge.
  - Hold `frog_arrive_InHigh` high for 20 cycles → exactly one crossing counted.
